// File: rtl/serial_pattern_generator.sv
// Serial bit-stream transmitter: shifts a captured pattern out MSB-first with a
// programmable bit period and repeat count, plus a start/busy/done handshake and status display.
module serial_pattern_generator #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned DIV_W = 8,
    parameter int unsigned REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [DIV_W-1:0] bit_period,
    input  logic [REP_W-1:0] reps,
    output logic             x_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done,
    output logic [7:0]       seg
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);

    localparam logic [7:0] SEG_DASH = 8'b0000_0010;
    localparam logic [7:0] SEG_ZERO = 8'b1111_1100;
    localparam logic [7:0] SEG_ONE  = 8'b0110_0000;
    localparam logic [7:0] SEG_DONE = 8'b1111_1111;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0] per_cnt_q, per_cnt_d;
    logic [REP_W-1:0] pass_cnt_q, pass_cnt_d;
    logic             x_q, x_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       seg_q, seg_d;

    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] next_idx;

    assign eff_len = (len == '0 || len > FULL_LEN) ? FULL_LEN : len;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        per_d      = per_q;
        reps_d     = reps_q;
        bit_idx_d  = bit_idx_q;
        per_cnt_d  = per_cnt_q;
        pass_cnt_d = pass_cnt_q;
        x_d        = 1'b1;
        strobe_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        seg_d      = seg_q;
        next_idx   = '0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d    = StShift;
                    pat_d      = pattern;
                    len_d      = eff_len;
                    per_d      = bit_period;
                    reps_d     = reps;
                    next_idx   = eff_len - ONE_LEN;
                    bit_idx_d  = next_idx;
                    per_cnt_d  = '0;
                    pass_cnt_d = '0;
                    x_d        = pattern[next_idx[IDX_W-1:0]];
                    strobe_d   = 1'b1;
                    busy_d     = 1'b1;
                    seg_d      = x_d ? SEG_ONE : SEG_ZERO;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                    seg_d   = SEG_DASH;
                end else if (per_cnt_q != per_q) begin
                    per_cnt_d = per_cnt_q + DIV_W'(1);
                    x_d       = x_q;
                    busy_d    = 1'b1;
                end else if (bit_idx_q == '0 && pass_cnt_q == reps_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    seg_d   = SEG_DONE;
                end else begin
                    // Next bit, or wrap to the top of the pattern for another pass.
                    if (bit_idx_q == '0) begin
                        next_idx   = len_q - ONE_LEN;
                        pass_cnt_d = pass_cnt_q + REP_W'(1);
                    end else begin
                        next_idx = bit_idx_q - ONE_LEN;
                    end
                    bit_idx_d = next_idx;
                    per_cnt_d = '0;
                    x_d       = pat_q[next_idx[IDX_W-1:0]];
                    strobe_d  = 1'b1;
                    busy_d    = 1'b1;
                    seg_d     = x_d ? SEG_ONE : SEG_ZERO;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pat_q      <= '0;
            len_q      <= '0;
            per_q      <= '0;
            reps_q     <= '0;
            bit_idx_q  <= '0;
            per_cnt_q  <= '0;
            pass_cnt_q <= '0;
            x_q        <= 1'b1;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seg_q      <= SEG_DASH;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            per_q      <= per_d;
            reps_q     <= reps_d;
            bit_idx_q  <= bit_idx_d;
            per_cnt_q  <= per_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            x_q        <= x_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            seg_q      <= seg_d;
        end
    end

    assign x_out      = x_q;
    assign bit_strobe = strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Self-checking bench for serial_pattern_generator: directed and random transfers against
// a bit-stream model built from pattern/len/period/reps arithmetic.
module tb_serial_pattern_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [7:0] bit_period;
    logic [3:0] reps;
    logic       x_out;
    logic       bit_strobe;
    logic       busy;
    logic       done;
    logic [7:0] seg;

    int checks   = 0;
    int failures = 0;

    bit exp_x[$];
    bit exp_s[$];

    serial_pattern_generator #(
        .PAT_W(8),
        .LEN_W(4),
        .DIV_W(8),
        .REP_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .len       (len),
        .bit_period(bit_period),
        .reps      (reps),
        .x_out     (x_out),
        .bit_strobe(bit_strobe),
        .busy      (busy),
        .done      (done),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    // 011 sequence detector clocked alongside the DUT, fed from x_out.
    logic [1:0] det_hist;
    logic       det_out;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            det_hist <= 2'b11;
            det_out  <= 1'b0;
        end else begin
            det_hist <= {det_hist[0], x_out};
            det_out  <= ({det_hist, x_out} == 3'b011);
        end
    end

    // Expected per-cycle x_out and bit_strobe for one whole transmission.
    function automatic void build_expect(input logic [7:0] pat, input int unsigned ln,
                                         input int unsigned per, input int unsigned rp);
        int unsigned eff;
        eff = (ln == 0 || ln > 8) ? 8 : ln;
        exp_x.delete();
        exp_s.delete();
        for (int p = 0; p <= int'(rp); p++)
            for (int b = int'(eff) - 1; b >= 0; b--)
                for (int c = 0; c <= int'(per); c++) begin
                    exp_x.push_back(1'(pat >> b));
                    exp_s.push_back(c == 0);
                end
    endfunction

    // Called just after a falling edge; returns at the falling edge of cycle t+1.
    task automatic start_txn(input logic [7:0] pat, input logic [3:0] ln,
                             input logic [7:0] per, input logic [3:0] rp);
        pattern    = pat;
        len        = ln;
        bit_period = per;
        reps       = rp;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        pattern    = 8'($urandom);
        len        = 4'($urandom);
        bit_period = 8'($urandom);
        reps       = 4'($urandom);
    endtask

    task automatic test_reset();
        bit saw;
        reset = 1'b1;
        #1;
        checks++;
        if (x_out !== 1'b1 || bit_strobe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            seg !== 8'b0000_0010)
            begin failures++; $display("FAIL reset_values: x=%b strobe=%b busy=%b done=%b seg=%b, want 1 0 0 0 00000010",
                x_out, bit_strobe, busy, done, seg); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_txn(8'hA5, 4'd8, 8'd3, 4'd0);
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL reset_mid_busy: busy=%b, want 1", busy); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (x_out !== 1'b1 || busy !== 1'b0 || seg !== 8'b0000_0010 || done !== 1'b0)
            begin failures++; $display("FAIL reset_async: x=%b busy=%b done=%b seg=%b, want 1 0 0 00000010",
                x_out, busy, done, seg); end
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin failures++; $display("FAIL reset_no_done: activity seen=1, want 0"); end
    endtask

    task automatic test_patterns();
        logic [7:0] tp[6] = '{8'h03, 8'h02, 8'h81, 8'h81, 8'h5A, 8'hC6};
        logic [3:0] tl[6] = '{4'd3, 4'd2, 4'd0, 4'd9, 4'd1, 4'd8};
        logic [7:0] tpr[6] = '{8'd0, 8'd2, 8'd0, 8'd1, 8'd0, 8'd1};
        logic [3:0] tr[6] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
        for (int v = 0; v < 6; v++) begin
            build_expect(tp[v], tl[v], tpr[v], tr[v]);
            start_txn(tp[v], tl[v], tpr[v], tr[v]);
            for (int k = 0; k < exp_x.size(); k++) begin
                checks++;
                if (x_out !== exp_x[k] || bit_strobe !== exp_s[k] || busy !== 1'b1 ||
                    done !== 1'b0 || seg !== (exp_x[k] ? 8'h60 : 8'hFC))
                    begin failures++; $display("FAIL pattern%0d[%0d]: x=%b strobe=%b busy=%b done=%b seg=%h, want x=%b strobe=%b busy=1 done=0",
                        v, k, x_out, bit_strobe, busy, done, seg, exp_x[k], exp_s[k]); end
                @(negedge clk);
            end
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || x_out !== 1'b1 || seg !== 8'hFF)
                begin failures++; $display("FAIL pattern%0d_done: done=%b busy=%b x=%b seg=%h, want 1 0 1 ff",
                    v, done, busy, x_out, seg); end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || seg !== 8'hFF)
                begin failures++; $display("FAIL pattern%0d_idle: done=%b seg=%h, want 0 ff", v, done, seg); end
        end
    endtask

    task automatic test_start_while_busy();
        build_expect(8'h81, 9, 1, 0);
        start_txn(8'h81, 4'd9, 8'd1, 4'd0);
        for (int k = 0; k < exp_x.size(); k++) begin
            start = (k >= 2 && k < exp_x.size() - 1);
            checks++;
            if (x_out !== exp_x[k] || bit_strobe !== exp_s[k] || busy !== 1'b1 || done !== 1'b0)
                begin failures++; $display("FAIL busy_start[%0d]: x=%b strobe=%b busy=%b done=%b, want x=%b strobe=%b busy=1 done=0",
                    k, x_out, bit_strobe, busy, done, exp_x[k], exp_s[k]); end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL busy_start_done: done=%b busy=%b, want 1 0", done, busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_queued: busy=%b, want 0", busy); end
    endtask

    task automatic test_back_to_back();
        bit want_busy[6] = '{1, 0, 0, 1, 0, 0};
        bit want_done[6] = '{0, 1, 0, 0, 1, 0};
        pattern    = 8'h01;
        len        = 4'd1;
        bit_period = 8'd0;
        reps       = 4'd0;
        start      = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) start = 1'b0;
            checks++;
            if (busy !== want_busy[k] || done !== want_done[k])
                begin failures++; $display("FAIL back_to_back[%0d]: busy=%b done=%b, want %b %b",
                    k, busy, done, want_busy[k], want_done[k]); end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL back_to_back_stop: busy=%b, want 0", busy); end
    endtask

    task automatic test_abort();
        bit saw;
        start_txn(8'h01, 4'd1, 8'd0, 4'd0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || seg !== 8'hFF || x_out !== 1'b1)
            begin failures++; $display("FAIL start_abort_idle: busy=%b seg=%h x=%b, want 0 ff 1", busy, seg, x_out); end
        start_txn(8'hC3, 4'd8, 8'd1, 4'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (bit_strobe !== 1'b1 || x_out !== 1'b1 || busy !== 1'b1)
            begin failures++; $display("FAIL abort_second_bit: strobe=%b x=%b busy=%b, want 1 1 1",
                bit_strobe, x_out, busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (x_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || seg !== 8'b0000_0010 || bit_strobe !== 1'b0)
            begin failures++; $display("FAIL abort_idle: x=%b busy=%b done=%b strobe=%b seg=%b, want 1 0 0 0 00000010",
                x_out, busy, done, bit_strobe, seg); end
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin failures++; $display("FAIL abort_no_done: activity seen=1, want 0"); end
    endtask

    task automatic test_random();
        logic [7:0] p;
        logic [3:0] l;
        logic [7:0] d;
        logic [3:0] r;
        int bad;
        for (int n = 0; n < 30; n++) begin
            p = 8'($urandom);
            l = 4'($urandom);
            d = 8'($urandom_range(0, 3));
            r = 4'($urandom_range(0, 3));
            if (n == 5) begin d = 8'hFF; l = 4'd1; r = 4'd0; end
            if (n == 6) begin r = 4'hF; d = 8'd0; end
            build_expect(p, l, d, r);
            start_txn(p, l, d, r);
            bad = 0;
            for (int k = 0; k < exp_x.size(); k++) begin
                if (x_out !== exp_x[k] || bit_strobe !== exp_s[k] || busy !== 1'b1 || done !== 1'b0) begin
                    if (bad == 0)
                        $display("FAIL random%0d[%0d]: x=%b strobe=%b busy=%b done=%b, want x=%b strobe=%b busy=1 done=0",
                            n, k, x_out, bit_strobe, busy, done, exp_x[k], exp_s[k]);
                    bad++;
                end
                @(negedge clk);
            end
            checks++;
            if (bad != 0) failures++;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || seg !== 8'hFF)
                begin failures++; $display("FAIL random%0d_done: done=%b busy=%b seg=%h, want 1 0 ff",
                    n, done, busy, seg); end
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_loopback();
        bit seq[$];
        bit want;
        int hits;
        build_expect(8'h03, 3, 0, 2);
        seq = {1'b1, 1'b1};
        foreach (exp_x[i]) seq.push_back(exp_x[i]);
        seq.push_back(1'b1);
        seq.push_back(1'b1);
        start_txn(8'h03, 4'd3, 8'd0, 4'd2);
        hits = 0;
        for (int k = 1; k < seq.size(); k++) begin
            want = (k >= 2) && !seq[k-2] && seq[k-1] && seq[k];
            if (det_out === 1'b1) hits++;
            checks++;
            if (det_out !== want)
                begin failures++; $display("FAIL loopback[%0d]: det=%b, want %b", k, det_out, want); end
            @(negedge clk);
        end
        checks++;
        if (hits != 3) begin failures++; $display("FAIL loopback_count: hits=%0d, want 3", hits); end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = '0;
        len        = '0;
        bit_period = '0;
        reps       = '0;
        test_reset();
        test_patterns();
        test_start_while_busy();
        test_back_to_back();
        test_abort();
        test_random();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_pattern_generator.md
Name: serial_pattern_generator

Overview:
Serial bit-stream transmitter that feeds the single-bit serial input of the team's sequence detectors. It loads a programmable pattern and shifts it out MSB-first with a programmable bit period and repeat count. It exposes a start/busy/done handshake and drives a 7-segment status display. It sits on the stimulus side of the detector's `x` input, either for on-chip loopback or for external pin drive.

Parameters:
PAT_W, 8, maximum pattern length in bits
LEN_W, 4, width of len input (must hold PAT_W)
DIV_W, 8, width of bit_period input
REP_W, 4, width of reps input

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  request transmission; sampled only in IDLE
abort  in  1  synchronous abort of a transmission in progress
pattern  in  PAT_W  bits to send; bit len-1 is sent first, bit 0 last
len  in  LEN_W  number of bits per pass; 0 or >PAT_W is treated as PAT_W
bit_period  in  DIV_W  each bit is held for bit_period+1 clocks
reps  in  REP_W  number of passes = reps+1
x_out  out  1  serial data; idle level 1
bit_strobe  out  1  1-cycle pulse on the first clock of every transmitted bit
busy  out  1  high while transmitting
done  out  1  1-cycle pulse on normal completion
seg  out  8  7-segment status

Behaviour:
- Reset is asynchronous and active-high. It forces IDLE from any state, including mid-transmission.
- Reset values: x_out=1, bit_strobe=0, busy=0, done=0, seg=8'b00000010. All counters and shadow registers are cleared.
- FSM states:
  - IDLE: x_out=1, busy=0. start=1 && abort=0 at edge t captures pattern, effective len, bit_period and reps into shadow registers; the FSM enters SHIFT. Inputs may change freely after capture.
  - SHIFT: x_out = shadow_pattern[bit_idx], with bit_idx starting at len-1.
    - A period counter counts 0..bit_period. At terminal count the block advances to the next bit.
    - After bit 0 of a pass: if passes remain, bit_idx reloads to len-1 and the next pass starts with no gap; otherwise the FSM enters DONE.
  - DONE: lasts exactly one cycle. done=1, busy=0, x_out=1; then the FSM returns to IDLE.
- Latency (start sampled at edge t):
  - From cycle t+1: busy=1, bit_strobe=1, x_out = first bit.
  - Total busy length = (reps+1) × len × (bit_period+1) cycles.
  - done is high in the cycle immediately after the final busy cycle.
- bit_strobe asserts on the first cycle of every bit, including the first bit of each repeated pass.
- start while busy or in DONE: ignored, with no queuing.
- abort:
  - In SHIFT: abort at an edge returns the FSM to IDLE at that edge, with x_out=1 and busy=0. No done pulse is issued. seg shows idle.
  - In IDLE: abort has no effect. If start and abort are both high, abort wins and start is ignored.
- Effective length: len=1 with bit_period=0 gives a single 1-cycle bit. len=PAT_W uses the full pattern.
- Counter wrap: bit_period = all-ones gives 2^DIV_W cycles per bit with no overflow. reps = all-ones gives 2^REP_W passes.
- seg encoding (registered, updated with the state):
  - IDLE, never completed since reset or abort: 8'b00000010 (dash).
  - SHIFT with x_out=0: 8'b11111100.
  - SHIFT with x_out=1: 8'b01100000.
  - From DONE onward: 8'b11111111 (all on, "8."). This value is held through IDLE until the next accepted start, abort, or reset.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset mid-transmission: start pattern=8'hA5, len=8, bit_period=3, reps=0; assert reset at cycle 10 -> x_out=1, busy=0, seg=8'b00000010 immediately (asynchronous); no done pulse.
- Basic pattern: pattern=8'b00000011, len=3, bit_period=0, reps=0, start at t -> x_out=0,1,1 at t+1..t+3; bit_strobe high at t+1..t+3; busy t+1..t+3; done at t+4 only; seg=8'b11111111 from t+4.
- Divider and repeat: pattern=8'b00000010, len=2, bit_period=2, reps=1 -> x_out=1,1,1,0,0,0,1,1,1,0,0,0; 4 bit_strobe pulses spaced 3 cycles apart; busy for 12 cycles; done at t+13.
- Boundary length: len=0 and len=9 both send all 8 bits of pattern=8'h81 (1,0,0,0,0,0,0,1); start asserted during busy has no effect and the cycle count is unchanged.
- Abort, and abort/start collision: abort at 2nd bit of an 8-bit send -> IDLE next edge, x_out=1, no done, seg=dash. Start and abort high together in IDLE -> stays IDLE.
- Loopback: x_out into the 011 sequence detector (detector clocked in lockstep), pattern=8'b00000011, len=3, bit_period=0, reps=2 -> detector output asserts exactly 3 times, one cycle after each completed "011".
